// File: rtl/layer_compositor.sv
// -----------------------------------------------------------------------------
// layer_compositor
//
// Purpose:
//   Priority compositor for N_LAYERS sprite layers, with a collision detector
//   between two layer groups (A = projectiles, B = targets/walls). A collision
//   is confirmed after CONFIRM_CNT consecutive overlap pixels. One hit is
//   reported per overlap run, tagged with the coordinate of the run's first
//   pixel.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   lcd_xpos     current pixel x coordinate (12 bit)
//   lcd_ypos     current pixel y coordinate (12 bit)
//   frame_start  one-cycle pulse on the first pixel of a frame
//   freeze       suspends hit detection while high
//   layer_valid  per-layer pixel valid, bit 0 = highest priority
//   layer_pixel  per-layer RGB888, layer i at [24i+23:24i]
//   lcd_data     composited pixel, one clock after the inputs
//   hit_valid    one-cycle pulse on a confirmed collision
//   hit_x/hit_y  first pixel of the confirmed overlap run
//   hit_layers   layer_valid snapshot at the confirming pixel
//   hit_count    (HIT_COUNT_EN only) saturating 8-bit hit counter,
//                cleared by frame_start
//
// Build option:
//   HIT_COUNT_EN  adds the hit_count output and its counter.
// -----------------------------------------------------------------------------
module layer_compositor #(
  parameter int                  N_LAYERS    = 8,
  parameter int                  CONFIRM_CNT = 2,
  parameter logic [N_LAYERS-1:0] A_MASK      = 8'h08,
  parameter logic [N_LAYERS-1:0] B_MASK      = 8'h70,
  parameter logic [23:0]         BG_COLOR    = 24'h030307
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [11:0]            lcd_xpos,
  input  logic [11:0]            lcd_ypos,
  input  logic                   frame_start,
  input  logic                   freeze,
  input  logic [N_LAYERS-1:0]    layer_valid,
  input  logic [24*N_LAYERS-1:0] layer_pixel,
  output logic [23:0]            lcd_data,
  output logic                   hit_valid,
  output logic [11:0]            hit_x,
  output logic [11:0]            hit_y,
  output logic [N_LAYERS-1:0]    hit_layers
`ifdef HIT_COUNT_EN
  ,
  output logic [7:0]             hit_count
`endif
);

  localparam logic [2:0] CONFIRM_C = 3'(CONFIRM_CNT);

  logic [23:0]         lcd_data_d,   lcd_data_q;
  logic [2:0]          cnt_d,        cnt_q;
  logic [11:0]         cand_x_d,     cand_x_q;
  logic [11:0]         cand_y_d,     cand_y_q;
  logic                hit_valid_d,  hit_valid_q;
  logic [11:0]         hit_x_d,      hit_x_q;
  logic [11:0]         hit_y_d,      hit_y_q;
  logic [N_LAYERS-1:0] hit_layers_d, hit_layers_q;
  logic                overlap;
  logic [2:0]          cnt_inc;

  // Scan from lowest priority to highest so the lowest valid index wins.
  always_comb begin
    lcd_data_d = BG_COLOR;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_valid[i]) lcd_data_d = layer_pixel[24*i +: 24];
    end
  end

  assign overlap = (|(layer_valid & A_MASK)) && (|(layer_valid & B_MASK));
  assign cnt_inc = cnt_q + 3'd1;

  always_comb begin
    cnt_d        = cnt_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    hit_valid_d  = 1'b0;
    hit_x_d      = hit_x_q;
    hit_y_d      = hit_y_q;
    hit_layers_d = hit_layers_q;
    if (frame_start) begin
      cnt_d = 3'd0;
    end else if (!freeze) begin
      if (overlap) begin
        if (cnt_q == 3'd0) begin
          cand_x_d = lcd_xpos;
          cand_y_d = lcd_ypos;
        end
        // Once saturated the counter sits at CONFIRM_C, so the equality
        // below can only fire once per run.
        if (cnt_q != CONFIRM_C) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CONFIRM_C) begin
            hit_valid_d  = 1'b1;
            // A run of length one has no registered candidate yet.
            hit_x_d      = (cnt_q == 3'd0) ? lcd_xpos : cand_x_q;
            hit_y_d      = (cnt_q == 3'd0) ? lcd_ypos : cand_y_q;
            hit_layers_d = layer_valid;
          end
        end
      end else begin
        cnt_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_data_q   <= '0;
      cnt_q        <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      hit_valid_q  <= 1'b0;
      hit_x_q      <= '0;
      hit_y_q      <= '0;
      hit_layers_q <= '0;
    end else begin
      lcd_data_q   <= lcd_data_d;
      cnt_q        <= cnt_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      hit_valid_q  <= hit_valid_d;
      hit_x_q      <= hit_x_d;
      hit_y_q      <= hit_y_d;
      hit_layers_q <= hit_layers_d;
    end
  end

  assign lcd_data   = lcd_data_q;
  assign hit_valid  = hit_valid_q;
  assign hit_x      = hit_x_q;
  assign hit_y      = hit_y_q;
  assign hit_layers = hit_layers_q;

`ifdef HIT_COUNT_EN
  logic [7:0] hit_count_d, hit_count_q;

  // Counts the registered pulse; frame_start wins over a coincident pulse.
  always_comb begin
    hit_count_d = hit_count_q;
    if (frame_start) begin
      hit_count_d = 8'd0;
    end else if (hit_valid_q && (hit_count_q != 8'hFF)) begin
      hit_count_d = hit_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_count_q <= '0;
    else        hit_count_q <= hit_count_d;
  end

  assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// -----------------------------------------------------------------------------
// tb_layer_compositor
//
// Two instances share the stimulus: u_dut (CONFIRM_CNT=2, defaults) and
// u_dut1 (CONFIRM_CNT=1). Compositing is driven from a vector table; the
// expected lcd_data is queued when a pixel is driven and popped one clock
// later. Collision corner cases use hand-written pixel sequences.
// -----------------------------------------------------------------------------
module tb_layer_compositor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [11:0]  lcd_xpos, lcd_ypos;
  logic         frame_start, freeze;
  logic [7:0]   layer_valid;
  logic [191:0] layer_pixel;

  logic [23:0]  lcd_data,   lcd_data1;
  logic         hit_valid,  hit_valid1;
  logic [11:0]  hit_x, hit_y, hit_x1, hit_y1;
  logic [7:0]   hit_layers, hit_layers1;
`ifdef HIT_COUNT_EN
  logic [7:0]   hit_count, hit_count1;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [23:0] sb[$];

  always #5 clk = ~clk;

  layer_compositor u_dut (
    .clk(clk), .rst_n(rst_n), .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos),
    .frame_start(frame_start), .freeze(freeze), .layer_valid(layer_valid),
    .layer_pixel(layer_pixel), .lcd_data(lcd_data), .hit_valid(hit_valid),
    .hit_x(hit_x), .hit_y(hit_y), .hit_layers(hit_layers)
`ifdef HIT_COUNT_EN
    , .hit_count(hit_count)
`endif
  );

  layer_compositor #(.CONFIRM_CNT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos),
    .frame_start(frame_start), .freeze(freeze), .layer_valid(layer_valid),
    .layer_pixel(layer_pixel), .lcd_data(lcd_data1), .hit_valid(hit_valid1),
    .hit_x(hit_x1), .hit_y(hit_y1), .hit_layers(hit_layers1)
`ifdef HIT_COUNT_EN
    , .hit_count(hit_count1)
`endif
  );

  typedef struct {
    logic [7:0]  valid;
    logic [23:0] p0;
    logic [23:0] p3;
    logic [23:0] exp_lcd;
    logic        exp_hv;
    logic        exp_hv1;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Layer i defaults to {i, i+16, i+32}; layers 0 and 3 can be overridden.
  task automatic set_pix(input logic [23:0] p0, input logic [23:0] p3);
    for (int i = 0; i < 8; i++) layer_pixel[24*i +: 24] = {8'(i), 8'(i + 16), 8'(i + 32)};
    layer_pixel[23:0]  = p0;
    layer_pixel[95:72] = p3;
  endtask

  // Expected colour for the layer patterns used in the sequences
  // (default layer colours).
  function automatic logic [23:0] lcd_exp(input logic [7:0] v);
    case (v)
      8'h28, 8'h18: return 24'h031323;
      8'h29:        return 24'h001020;
      default:      return 24'h030307;
    endcase
  endfunction

  task automatic step(input logic ehv, input logic ehv1, input logic [23:0] elcd, input string tag);
    sb.push_back(elcd);
    @(posedge clk);
    #1;
    if (sb.size() > 0) chk({tag, " lcd_data"}, lcd_data, sb.pop_front());
    chk({tag, " hit_valid"},  hit_valid,  ehv);
    chk({tag, " hit_valid1"}, hit_valid1, ehv1);
  endtask

  // One pixel of a sequence: set coordinate and layers, then step.
  task automatic pix(input int x, input int y, input logic [7:0] v,
                     input logic ehv, input logic ehv1, input string tag);
    lcd_xpos    = 12'(x);
    lcd_ypos    = 12'(y);
    layer_valid = v;
    step(ehv, ehv1, lcd_exp(v), tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h00, 24'h001020, 24'h031323, 24'h030307, 1'b0, 1'b0};
    vecs[1] = '{8'h09, 24'hFF0000, 24'h00FF00, 24'hFF0000, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 24'hFF0000, 24'h00FF00, 24'h030307, 1'b0, 1'b0};
    vecs[3] = '{8'h08, 24'hFF0000, 24'h00FF00, 24'h00FF00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 24'hFF0000, 24'h00FF00, 24'h071727, 1'b0, 1'b0};
    vecs[5] = '{8'h60, 24'hFF0000, 24'h00FF00, 24'h051525, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 24'hABCDEF, 24'h00FF00, 24'hABCDEF, 1'b0, 1'b1};
    vecs[7] = '{8'h02, 24'hABCDEF, 24'h00FF00, 24'h011121, 1'b0, 1'b0};
    vecs[8] = '{8'h01, 24'h123456, 24'h00FF00, 24'h123456, 1'b0, 1'b0};

    rst_n = 1'b0; lcd_xpos = '0; lcd_ypos = '0; frame_start = 1'b0;
    freeze = 1'b0; layer_valid = '0;
    set_pix(24'h001020, 24'h031323);
    layer_valid = 8'h28;
    repeat (2) @(posedge clk);
    #1;
    chk("reset lcd_data",   lcd_data,   0);
    chk("reset hit_valid",  hit_valid,  0);
    chk("reset hit_x",      hit_x,      0);
    chk("reset hit_y",      hit_y,      0);
    chk("reset hit_layers", hit_layers, 0);
    layer_valid = 8'h00;
    rst_n = 1'b1;

    // Compositing table
    for (int i = 0; i < 9; i++) begin
      layer_valid = vecs[i].valid;
      set_pix(vecs[i].p0, vecs[i].p3);
      step(vecs[i].exp_hv, vecs[i].exp_hv1, vecs[i].exp_lcd, $sformatf("vec%0d", i));
    end
    set_pix(24'h001020, 24'h031323);

    // Layers 3+5 overlap x=100..104, y=40: one hit after x=101
    for (int x = 98; x <= 106; x++) begin
      pix(x, 40, (x >= 100 && x <= 104) ? 8'h28 : 8'h00,
          x == 101, x == 100, $sformatf("run x=%0d", x));
    end
    chk("run hit_x",       hit_x,       100);
    chk("run hit_y",       hit_y,       40);
    chk("run hit_layers",  hit_layers,  8'h28);
    chk("run hit_x1",      hit_x1,      100);

    // Single-pixel overlap at x=7
    pix(6, 3, 8'h00, 0, 0, "single x=6");
    pix(7, 3, 8'h18, 0, 1, "single x=7");
    pix(8, 3, 8'h00, 0, 0, "single x=8");
    chk("single hit_x held",  hit_x,       100);
    chk("single hit_x1",      hit_x1,      7);
    chk("single hit_y1",      hit_y1,      3);
    chk("single hit_layers1", hit_layers1, 8'h18);

    // frame_start clears the run and masks the coincident overlap
    pix(50, 9, 8'h28, 0, 1, "fs x=50");
    frame_start = 1'b1;
    pix(51, 9, 8'h28, 0, 0, "fs x=51");
    frame_start = 1'b0;
    pix(52, 9, 8'h28, 0, 1, "fs x=52");
    pix(53, 9, 8'h28, 1, 0, "fs x=53");
    pix(54, 9, 8'h00, 0, 0, "fs x=54");
    chk("fs hit_x", hit_x, 52);

    // freeze across a whole 4-pixel overlap: nothing happens
    freeze = 1'b1;
    for (int x = 10; x <= 13; x++) pix(x, 11, (x % 2 == 0) ? 8'h28 : 8'h29, 0, 0, $sformatf("frz x=%0d", x));
    pix(14, 11, 8'h00, 0, 0, "frz x=14");
    freeze = 1'b0;
    // Run starts, freezes mid-run, then resumes from the held count
    pix(200, 12, 8'h28, 0, 1, "frz x=200");
    freeze = 1'b1;
    for (int x = 201; x <= 204; x++) pix(x, 12, (x % 2 == 0) ? 8'h28 : 8'h29, 0, 0, $sformatf("frz x=%0d", x));
    freeze = 1'b0;
    pix(205, 12, 8'h28, 1, 0, "frz x=205");
    pix(206, 12, 8'h00, 0, 0, "frz x=206");
    chk("frz hit_x", hit_x, 200);
    chk("frz hit_y", hit_y, 12);

    // Reset mid-run aborts it
    pix(300, 5, 8'h28, 0, 1, "rst x=300");
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst lcd_data",   lcd_data,   0);
    chk("midrst hit_x",      hit_x,      0);
    chk("midrst hit_y",      hit_y,      0);
    chk("midrst hit_layers", hit_layers, 0);
    chk("midrst hit_valid1", hit_valid1, 0);
    lcd_xpos = 12'd301;
    step(0, 0, 24'h000000, "rst x=301");
    rst_n = 1'b1;
    pix(302, 5, 8'h28, 0, 1, "rst x=302");
    pix(303, 5, 8'h28, 1, 0, "rst x=303");
    pix(304, 5, 8'h00, 0, 0, "rst x=304");
    chk("rst hit_x", hit_x, 302);

`ifdef HIT_COUNT_EN
    frame_start = 1'b1;
    pix(0, 0, 8'h00, 0, 0, "hc clr");
    frame_start = 1'b0;
    chk("hc cleared", hit_count, 0);
    for (int n = 0; n < 300; n++) begin
      pix(1, 1, 8'h28, 0, 1, "hc a");
      pix(2, 1, 8'h28, 1, 0, "hc b");
      pix(3, 1, 8'h00, 0, 0, "hc c");
    end
    chk("hc saturated", hit_count, 255);
    frame_start = 1'b1;
    pix(0, 0, 8'h00, 0, 0, "hc fs");
    frame_start = 1'b0;
    chk("hc frame clear", hit_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter N_LAYERS, default 8: number of sprite layers, legal range 2..16.
REQ-002 Parameter CONFIRM_CNT, default 2: consecutive overlap pixels that confirm a hit, legal range 1..7.
REQ-003 Parameter A_MASK, default 8'h08: N_LAYERS-bit mask selecting collision group A (projectiles).
REQ-004 Parameter B_MASK, default 8'h70: N_LAYERS-bit mask selecting collision group B (targets/walls).
REQ-005 Parameter BG_COLOR, default 24'h030307: output colour when no layer is valid.
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 lcd_xpos  input  12  current pixel x coordinate.
REQ-009 lcd_ypos  input  12  current pixel y coordinate.
REQ-010 frame_start  input  1  one-cycle pulse at the first pixel of a frame.
REQ-011 freeze  input  1  suspends hit detection while high.
REQ-012 layer_valid  input  N_LAYERS  per-layer pixel-valid; bit 0 has highest priority.
REQ-013 layer_pixel  input  24*N_LAYERS  per-layer colour; layer i occupies bits [24i+23:24i].
REQ-014 lcd_data  output  24  composited pixel colour, registered.
REQ-015 hit_valid  output  1  one-cycle pulse on a confirmed collision.
REQ-016 hit_x, hit_y  output  12 each  coordinate of the first pixel of the confirmed overlap run.
REQ-017 hit_layers  output  N_LAYERS  snapshot of layer_valid at the confirming pixel.

Function
REQ-018 lcd_data SHALL equal the pixel of the lowest-index valid layer, or BG_COLOR if none is valid, with exactly one clock of latency.
REQ-019 overlap SHALL be true when (layer_valid & A_MASK) is non-zero and (layer_valid & B_MASK) is non-zero in the same cycle.
REQ-020 A 3-bit run counter SHALL increment on each overlap cycle, saturating at CONFIRM_CNT, and clear to 0 on any non-overlap cycle.
REQ-021 When overlap occurs with the counter at 0, the current lcd_xpos/lcd_ypos SHALL be captured as the candidate coordinate.
REQ-022 hit_valid SHALL pulse high for one cycle, in the cycle after the overlap pixel that brings the counter to CONFIRM_CNT; hit_x, hit_y and hit_layers SHALL update in that same cycle.
REQ-023 Only one hit SHALL be reported per run; a run longer than CONFIRM_CNT SHALL NOT produce further pulses.
REQ-024 With CONFIRM_CNT=1, the first overlap pixel SHALL confirm, and hit_x/hit_y SHALL equal that pixel.
REQ-025 hit_x, hit_y and hit_layers SHALL hold their value until the next hit; a non-overlap cycle SHALL NOT clear them.
REQ-026 While freeze is high, the counter and candidate SHALL hold, hit_valid SHALL stay 0, and lcd_data SHALL keep updating.
REQ-027 frame_start SHALL clear the counter and take precedence over a simultaneous overlap, so that overlap is ignored in that cycle.
REQ-028 Overlap on the last pixel of a line SHALL continue the run into the next pixel; no line-boundary handling is required.

Reset
REQ-029 While rst_n is low, lcd_data, hit_x, hit_y, hit_layers, the counter and the candidate SHALL be 0, and hit_valid SHALL be 0.
REQ-030 Reset asserted mid-run SHALL abort the run with no hit pulse; after release, the first overlap SHALL start a new run.

Configuration
REQ-031 When HIT_COUNT_EN is defined, an 8-bit output hit_count SHALL count hit_valid pulses, saturate at 255, and clear on frame_start; frame_start wins over a simultaneous hit.
REQ-032 When HIT_COUNT_EN is not defined, the hit_count port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Layer 0 and layer 3 both valid, with colours 24'hFF0000 and 24'h00FF00 -> lcd_data = 24'hFF0000 one cycle later; no layer valid -> 24'h030307.
REQ-034 Layers 3 and 5 overlap at x=100..104, y=40, with CONFIRM_CNT=2 -> exactly one hit_valid, in the cycle after x=101, with hit_x=100, hit_y=40, hit_layers=8'h28.
REQ-035 Single-pixel overlap at x=7, with CONFIRM_CNT=2 -> no hit; the same stimulus with CONFIRM_CNT=1 -> hit with hit_x=7.
REQ-036 freeze high during a 4-pixel overlap -> no hit; freeze drops with overlap still present -> the run resumes from its held count.
REQ-037 rst_n pulsed low after the first overlap pixel -> no hit; all outputs read 0 during reset.
REQ-038 With HIT_COUNT_EN defined, 300 confirmed hits -> hit_count = 255; frame_start -> hit_count = 0.
